dsp48_arbiter_2x: RTL and testbench

DSP48_ARBITER_2X -- requirements
Module: dsp48_arbiter_2x

---
 rtl/dsp48_arbiter_2x_if.sv | 36 +++
 rtl/dsp48_arbiter_2x.sv | 145 ++++++++++++++
 tb/tb_dsp48_arbiter_2x.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsp48_arbiter_2x_if.sv
// Bundle between the two DSP requesters and the shared DSP48A1 slice.
// slave: arbiter side; master: requester/DSP side.
interface dsp48_arbiter_2x_if;
  logic        req_0;
  logic        req_1;
  logic        gnt_0;
  logic        gnt_1;
  logic [91:0] dsp_ins_flat_0;
  logic [91:0] dsp_ins_flat_1;
  logic [91:0] dsp_ins_flat;
  logic [47:0] dsp_outs_flat;
  logic [47:0] dsp_outs_flat_0;
  logic [47:0] dsp_outs_flat_1;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  req_0, req_1,
    input  dsp_ins_flat_0, dsp_ins_flat_1,
    input  dsp_outs_flat,
    output gnt_0, gnt_1,
    output dsp_ins_flat,
    output dsp_outs_flat_0, dsp_outs_flat_1,
    output busy, timeout_err
  );

  modport master (
    output req_0, req_1,
    output dsp_ins_flat_0, dsp_ins_flat_1,
    output dsp_outs_flat,
    input  gnt_0, gnt_1,
    input  dsp_ins_flat,
    input  dsp_outs_flat_0, dsp_outs_flat_1,
    input  busy, timeout_err
  );
endinterface

// File: rtl/dsp48_arbiter_2x.sv
// Two-port arbiter sharing one DSP48A1: round-robin grant, drain, hold limit.
// Ports: clk, reset (sync, active-low), bus (slave modport of the bundle).
module dsp48_arbiter_2x #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_HOLD     = 256
) (
  input  logic               clk,
  input  logic               reset,
  dsp48_arbiter_2x_if.slave  bus
);

  localparam int HW =
    (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [DW-1:0] DRAIN_LOAD =
    DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1,
    DRAIN
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            gnt_0;
  logic            gnt_1;
  logic            gnt_0_n;
  logic            gnt_1_n;
  logic            last;
  logic            last_n;
  logic            lock_0;
  logic            lock_1;
  logic            lock_0_n;
  logic            lock_1_n;
  logic            terr;
  logic            terr_n;
  logic [DW-1:0]   drain_cnt;
  logic [DW-1:0]   drain_cnt_n;
  logic [HW-1:0]   hold_cnt;
  logic [HW-1:0]   hold_cnt_n;
  logic            eff_0;
  logic            eff_1;
  logic            own_req;
  logic            hold_hit;

  // A port released by force stays locked out until it drops req.
  assign eff_0    = bus.req_0 & ~lock_0;
  assign eff_1    = bus.req_1 & ~lock_1;
  assign hold_hit = HOLD_EN && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      gnt_0     <= 1'b0;
      gnt_1     <= 1'b0;
      last      <= 1'b1;
      lock_0    <= 1'b0;
      lock_1    <= 1'b0;
      terr      <= 1'b0;
      drain_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_n;
      gnt_0     <= gnt_0_n;
      gnt_1     <= gnt_1_n;
      last      <= last_n;
      lock_0    <= lock_0_n;
      lock_1    <= lock_1_n;
      terr      <= terr_n;
      drain_cnt <= drain_cnt_n;
      hold_cnt  <= hold_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    last_n      = last;
    terr_n      = terr;
    lock_0_n    = lock_0 & bus.req_0;
    lock_1_n    = lock_1 & bus.req_1;
    drain_cnt_n = drain_cnt;
    hold_cnt_n  = hold_cnt;
    own_req     = 1'b0;
    unique case (state)
      IDLE: begin
        if (eff_0 && (!eff_1 || last)) begin
          state_n    = OWN0;
          last_n     = 1'b0;
          hold_cnt_n = '0;
        end else if (eff_1) begin
          state_n    = OWN1;
          last_n     = 1'b1;
          hold_cnt_n = '0;
        end
      end
      OWN0, OWN1: begin
        own_req = (state == OWN0) ? bus.req_0
                                  : bus.req_1;
        if (!own_req || hold_hit) begin
          // Still requesting here means the hold limit forced us out.
          if (own_req) begin
            terr_n = 1'b1;
            if (state == OWN0) lock_0_n = 1'b1;
            else               lock_1_n = 1'b1;
          end
          drain_cnt_n = DRAIN_LOAD;
          state_n = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
        end else if (HOLD_EN) begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_n = IDLE;
        else drain_cnt_n = drain_cnt - DW'(1);
      end
      default: state_n = IDLE;
    endcase
    gnt_0_n = (state_n == OWN0);
    gnt_1_n = (state_n == OWN1);
  end

  // Idle/drain feeds zeros: opmode 0 and no clock enables.
  always_comb begin
    bus.dsp_ins_flat = '0;
    unique case (1'b1)
      gnt_0:   bus.dsp_ins_flat = bus.dsp_ins_flat_0;
      gnt_1:   bus.dsp_ins_flat = bus.dsp_ins_flat_1;
      default: bus.dsp_ins_flat = '0;
    endcase
  end

  assign bus.gnt_0           = gnt_0;
  assign bus.gnt_1           = gnt_1;
  assign bus.busy            = (state != IDLE);
  assign bus.timeout_err     = terr;
  assign bus.dsp_outs_flat_0 = bus.dsp_outs_flat;
  assign bus.dsp_outs_flat_1 = bus.dsp_outs_flat;

endmodule

// File: tb/tb_dsp48_arbiter_2x.sv
// Bench for dsp48_arbiter_2x: cycle vectors, scoreboard, result path.
// dut_a: DRAIN 3 / MAX_HOLD 16; dut_t: DRAIN 3 / MAX_HOLD 8.
module tb_dsp48_arbiter_2x;

  typedef struct {
    bit t;
    bit rst;
    bit r0;
    bit r1;
    bit g0;
    bit g1;
    bit bz;
    bit te;
  } vec_t;

  typedef struct {
    bit t;
    bit g0;
    bit g1;
    bit bz;
    bit te;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_t;
  int   checks = 0;
  int   fails  = 0;

  vec_t vecs[$];
  exp_t sb[$];

  logic [47:0] p0 = '0;
  logic [47:0] p1 = '0;
  logic [47:0] p2 = '0;

  always #5 clk = ~clk;

  dsp48_arbiter_2x_if ifa ();
  dsp48_arbiter_2x_if ift ();

  dsp48_arbiter_2x #(
    .DRAIN_CYCLES(3),
    .MAX_HOLD(16)
  ) dut_a (
    .clk(clk),
    .reset(rst_a),
    .bus(ifa.slave)
  );

  dsp48_arbiter_2x #(
    .DRAIN_CYCLES(3),
    .MAX_HOLD(8)
  ) dut_t (
    .clk(clk),
    .reset(rst_t),
    .bus(ift.slave)
  );

  // Stand-in for the DSP48A1: A*B with a 3-stage pipeline.
  always @(posedge clk) begin
    p0 <= 48'(ifa.dsp_ins_flat[17:0])
        * 48'(ifa.dsp_ins_flat[35:18]);
    p1 <= p0;
    p2 <= p1;
  end
  assign ifa.dsp_outs_flat = p2;

  task automatic chk(string nm, int row,
                     logic [91:0] act, logic [91:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s row %0d: got %h want %h",
               nm, row, act, want);
    end
  endtask

  task automatic add(int n, bit t, bit rst, bit r0, bit r1,
                     bit g0, bit g1, bit bz, bit te);
    vec_t v;
    v.t = t; v.rst = rst; v.r0 = r0; v.r1 = r1;
    v.g0 = g0; v.g1 = g1; v.bz = bz; v.te = te;
    repeat (n) vecs.push_back(v);
  endtask

  function automatic logic [91:0] rnd92();
    return 92'({$urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [91:0] want;
    logic [91:0] act;
    logic [47:0] prod;
    bit          found;
    bit          inwin;

    rst_a = 1'b0; rst_t = 1'b0;
    ifa.req_0 = 1'b0; ifa.req_1 = 1'b0;
    ift.req_0 = 1'b0; ift.req_1 = 1'b0;
    ifa.dsp_ins_flat_0 = '0; ifa.dsp_ins_flat_1 = '0;
    ift.dsp_ins_flat_0 = '0; ift.dsp_ins_flat_1 = '0;
    ift.dsp_outs_flat = '0;

    //  n  t rst r0 r1  g0 g1 bz te
    add(1, 0, 0, 1, 1,  0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0);
    add(2, 0, 1, 1, 0,  1, 0, 1, 0);
    add(3, 0, 1, 0, 0,  0, 0, 1, 0);
    add(1, 0, 1, 0, 0,  0, 0, 0, 0);
    add(2, 0, 1, 1, 1,  0, 1, 1, 0);
    add(3, 0, 1, 1, 0,  0, 0, 1, 0);
    add(1, 0, 1, 1, 0,  0, 0, 0, 0);
    add(1, 0, 1, 1, 0,  1, 0, 1, 0);
    add(3, 0, 1, 0, 1,  0, 0, 1, 0);
    add(1, 0, 1, 0, 1,  0, 0, 0, 0);
    add(1, 0, 1, 0, 1,  0, 1, 1, 0);
    add(3, 0, 1, 0, 0,  0, 0, 1, 0);
    add(1, 0, 1, 0, 0,  0, 0, 0, 0);
    add(1, 0, 1, 1, 0,  1, 0, 1, 0);
    add(3, 0, 1, 0, 0,  0, 0, 1, 0);
    add(1, 0, 1, 0, 0,  0, 0, 0, 0);
    add(1, 0, 1, 1, 0,  1, 0, 1, 0);
    add(1, 0, 1, 1, 1,  1, 0, 1, 0);
    add(3, 0, 1, 0, 1,  0, 0, 1, 0);
    add(1, 0, 1, 0, 1,  0, 0, 0, 0);
    add(1, 0, 1, 0, 1,  0, 1, 1, 0);
    add(1, 0, 0, 1, 1,  0, 0, 0, 0);
    add(1, 0, 1, 1, 1,  1, 0, 1, 0);
    add(1, 0, 1, 0, 0,  0, 0, 1, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0);
    add(1, 0, 1, 1, 1,  1, 0, 1, 0);
    add(3, 0, 1, 0, 0,  0, 0, 1, 0);
    add(1, 0, 1, 0, 0,  0, 0, 0, 0);
    add(1, 1, 0, 0, 0,  0, 0, 0, 0);
    add(8, 1, 1, 1, 0,  1, 0, 1, 0);
    add(3, 1, 1, 1, 0,  0, 0, 1, 1);
    add(1, 1, 1, 1, 0,  0, 0, 0, 1);
    add(1, 1, 1, 1, 1,  0, 1, 1, 1);
    add(3, 1, 1, 0, 0,  0, 0, 1, 1);
    add(1, 1, 1, 0, 0,  0, 0, 0, 1);
    add(1, 1, 1, 1, 0,  1, 0, 1, 1);
    add(1, 1, 1, 0, 0,  0, 0, 1, 1);
    add(1, 1, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (!vecs[i].t) begin
        rst_a = vecs[i].rst;
        ifa.req_0 = vecs[i].r0;
        ifa.req_1 = vecs[i].r1;
        ifa.dsp_ins_flat_0 = rnd92();
        ifa.dsp_ins_flat_1 = rnd92();
      end else begin
        rst_t = vecs[i].rst;
        ift.req_0 = vecs[i].r0;
        ift.req_1 = vecs[i].r1;
        ift.dsp_ins_flat_0 = rnd92();
        ift.dsp_ins_flat_1 = rnd92();
        ift.dsp_outs_flat = 48'(rnd92());
      end
      e.t = vecs[i].t; e.g0 = vecs[i].g0;
      e.g1 = vecs[i].g1; e.bz = vecs[i].bz;
      e.te = vecs[i].te;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (!e.t) begin
        want = e.g0 ? ifa.dsp_ins_flat_0 :
               e.g1 ? ifa.dsp_ins_flat_1 : '0;
        chk("a_gnt_0", i, 92'(ifa.gnt_0), 92'(e.g0));
        chk("a_gnt_1", i, 92'(ifa.gnt_1), 92'(e.g1));
        chk("a_busy", i, 92'(ifa.busy), 92'(e.bz));
        chk("a_terr", i, 92'(ifa.timeout_err), 92'(e.te));
        chk("a_mux", i, ifa.dsp_ins_flat, want);
        chk("a_out0", i, 92'(ifa.dsp_outs_flat_0),
            92'(p2));
        chk("a_out1", i, 92'(ifa.dsp_outs_flat_1),
            92'(p2));
      end else begin
        want = e.g0 ? ift.dsp_ins_flat_0 :
               e.g1 ? ift.dsp_ins_flat_1 : '0;
        act = 92'(ift.dsp_outs_flat);
        chk("t_gnt_0", i, 92'(ift.gnt_0), 92'(e.g0));
        chk("t_gnt_1", i, 92'(ift.gnt_1), 92'(e.g1));
        chk("t_busy", i, 92'(ift.busy), 92'(e.bz));
        chk("t_terr", i, 92'(ift.timeout_err), 92'(e.te));
        chk("t_mux", i, ift.dsp_ins_flat, want);
        chk("t_out0", i, 92'(ift.dsp_outs_flat_0), act);
        chk("t_out1", i, 92'(ift.dsp_outs_flat_1), act);
      end
    end

    // Result path: 1234 * 567 through port 0, one-cycle burst.
    prod = 48'd1234 * 48'd567;
    @(negedge clk);
    ifa.dsp_ins_flat_0 = {56'd0, 18'd567, 18'd1234};
    ifa.req_0 = 1'b1;
    @(posedge clk);
    #1;
    chk("res_gnt", 0, 92'(ifa.gnt_0), 92'(1));
    @(negedge clk);
    ifa.req_0 = 1'b0;
    found = 1'b0;
    inwin = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(posedge clk);
      #1;
      if (ifa.dsp_outs_flat_0 === prod &&
          ifa.dsp_outs_flat_1 === prod) begin
        found = 1'b1;
        inwin = ifa.busy;
      end
    end
    chk("res_seen", 1, 92'(found), 92'(1));
    chk("res_in_drain", 2, 92'(inwin), 92'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
